ysyx_22041211_instenc: RTL and testbench
========================================

# ysyx_22041211_instEnc

Instruction encoder: the write-side counterpart of the core's immediate extraction. It accepts symbolic encode requests (op, rd, rs1, 32-bit immediate) over a valid/ready handshake and packs them into RV32I I-, U- and J-format instruction words. Encoded words go into a small FIFO that drains over a second valid/ready port toward the instruction-memory loader and self-test stimulus path. A two-instruction `LI` pseudo-op expands a full 32-bit constant into `LUI`+`ADDI`.

## Interface
- `DATA_LEN`, 32, instruction and immediate width.
- `DEPTH`, 4, output FIFO entries; must be a power of two and at least 2.

- `clk` in 1: the only clock; everything is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle when `req_valid && req_ready`.
- `req_op` in 3: 000 ADDI, 001 LUI, 010 AUIPC, 011 JAL, 100 LI; 101–111 are illegal.
- `req_rd` in 5: destination register.
- `req_rs1` in 5: source register; used by ADDI only.
- `req_imm` in `DATA_LEN`: byte-value immediate.
- `inst_valid` out 1: FIFO non-empty.
- `inst_ready` in 1: consumer pops on `inst_valid && inst_ready`.
- `inst` out `DATA_LEN`: FIFO head; reads 0 when empty.
- `imm_err` out 1: one-cycle pulse, registered, flagging a rejected request.

## Operation
- **ADDI**
  - Encoding: `{imm[11:0], rs1, 3'b000, rd, 7'b0010011}`.
  - Error if imm is outside −2048..2047.
- **LUI / AUIPC**
  - Encoding: `{imm[31:12], rd, opcode}`, with opcode 0110111 for LUI and 0010111 for AUIPC.
  - `imm[11:0]` is ignored and never flagged.
- **JAL**
  - Encoding: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}`.
  - Error if `imm[0]` is 1, or imm is outside −2^20..2^20−2.
- **LI**
  - If imm fits signed 12 bits: emit a single `ADDI rd, x0, imm`.
  - Otherwise emit `LUI rd, hi` with `hi = imm[31:12] + imm[11]` (mod 2^20).
  - Then, only if `imm[11:0] != 0`, emit `ADDI rd, rd, sext(imm[11:0])`.
- **Rejected requests**
  - Applies to errors and illegal ops.
  - The request is accepted (handshake completes) and nothing is pushed.
  - `imm_err` = 1 on the following cycle only.
- **FSM states**
  - `IDLE`:
    - `req_ready = (count < DEPTH)`.
    - An accepted request pushes its first word on the same edge.
    - LI needing a second word goes to `LI_LO`; everything else stays in `IDLE`.
  - `LI_LO`:
    - `req_ready = 0`.
    - The latched `rd` and low 12 bits push the ADDI on the first edge with `count < DEPTH`, then return to `IDLE`.
- **FIFO**
  - Circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH)+1` bits.
  - Push and pop on the same edge leave `count` unchanged.
- **Back-pressure**
  - `req_ready` and the `LI_LO` push decision use the registered `count` only; there is no same-cycle pop bypass.
  - When full, a same-cycle pop does not enable a push.

## Timing
- Reset (rst high at an edge):
  - State `IDLE`, pointers 0, `count` 0.
  - `inst_valid`=0, `inst`=0, `imm_err`=0.
  - `req_ready`=0 while rst is high; `req_ready`=1 on the first cycle after rst falls.
- Latency:
  - A word pushed at edge N is visible on `inst`/`inst_valid` after edge N.
  - Single-word ops: accept at edge N, first output in cycle N+1.
  - LI with two words: LUI pushed at edge N, ADDI at edge N+1 (if space); `req_ready` is 0 in cycle N+1.
- `imm_err` asserts in the cycle after acceptance and clears the cycle after that. Back-to-back errors give a continuous high.
- `inst` is combinational from the FIFO storage and the read pointer; it is stable while `inst_valid && !inst_ready`.
- Reset during `LI_LO` drops the pending ADDI and flushes the FIFO.

## Configuration
- `YSYX_22041211_ENC_LI_EN`
  - Defined: the LI pseudo-op and the `LI_LO` state are built.
  - Undefined: op 100 is illegal and produces an `imm_err` pulse. The FSM collapses to `IDLE` only, and `req_ready = (count < DEPTH)` always.

## Test plan
- **ADDI:** rd=1, rs1=0, imm=−1 → `inst`=0xFFF00093 one cycle after accept; `imm_err`=0.
- **LUI and JAL:**
  - LUI rd=5, imm=0x12345ABC → 0x123452B7.
  - JAL rd=1, imm=0x800 → 0x001000EF.
- **LI expansion:**
  - rd=10, imm=0x12345FFF → 0x12346537 then 0xFFF50513 on consecutive edges, with `req_ready` low for one cycle.
  - rd=10, imm=5 → single word 0x00500513.
- **Errors:**
  - ADDI imm=2048 → no push, `imm_err` pulses one cycle.
  - JAL imm=3 → same response.
  - op=111 → same response.
  - Without `YSYX_22041211_ENC_LI_EN`: LI imm=5 → same response.
- **Full and wrap:**
  - With `inst_ready`=0, four ADDIs are accepted and `req_ready` then drops.
  - Raise `inst_ready` for one cycle → `req_ready` is 1 the next cycle.
  - Ten further pushes and pops return words in order across pointer wrap.
- **Reset mid-operation:** assert rst in `LI_LO` with 3 entries queued → next cycle `inst_valid`=0, `inst`=0, `count` 0, and no ADDI is emitted afterward.

Source files
------------

// File: rtl/ysyx_22041211_instenc.sv
// Instruction encoder: packs ADDI/LUI/AUIPC/JAL requests into RV32I words and queues them in a small FIFO.
// Optional macro YSYX_22041211_ENC_LI_EN builds the two-word LI pseudo-op (LUI + ADDI) and its LI_LO state.
module ysyx_22041211_instenc #(
    parameter int DATA_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // Both ports: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [4:0]              req_rd,
    input  logic [4:0]              req_rs1,
    input  logic [DATA_LEN-1:0]     req_imm,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_LEN-1:0]     inst,
    output logic                    imm_err,
    output logic                    dbg_state,
    output logic [$clog2(DEPTH):0]  dbg_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_ADDI  = 3'b000;
    localparam logic [2:0] OP_LUI   = 3'b001;
    localparam logic [2:0] OP_AUIPC = 3'b010;
    localparam logic [2:0] OP_JAL   = 3'b011;
`ifdef YSYX_22041211_ENC_LI_EN
    localparam logic [2:0] OP_LI    = 3'b100;
`endif

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    typedef enum logic {
        IDLE  = 1'b0,
        LI_LO = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]       wptr, rptr;
    logic [CW-1:0]       count;
    logic                space, accept, push, pop;
    logic [DATA_LEN-1:0] push_word;

    logic                fits12, fits21;
    logic [DATA_LEN-1:0] enc_word;
    logic                enc_err;

`ifdef YSYX_22041211_ENC_LI_EN
    logic                enc_two;
    logic [19:0]         li_hi;
    logic [4:0]          lo_rd;
    logic [11:0]         lo_imm;
    logic [DATA_LEN-1:0] lo_word;

    // LUI takes the upper part rounded so that the sign-extended low ADDI lands on the exact value.
    assign li_hi   = req_imm[DATA_LEN-1:12] + {19'd0, req_imm[11]};
    assign lo_word = {lo_imm, lo_rd, 3'b000, lo_rd, OPC_OPIMM};
`endif

    assign fits12 = (&req_imm[DATA_LEN-1:11]) | ~(|req_imm[DATA_LEN-1:11]);
    assign fits21 = (&req_imm[DATA_LEN-1:20]) | ~(|req_imm[DATA_LEN-1:20]);

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
`ifdef YSYX_22041211_ENC_LI_EN
        enc_two  = 1'b0;
`endif
        case (req_op)
            OP_ADDI: begin
                enc_err  = ~fits12;
                enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_OPIMM};
            end
            OP_LUI:   enc_word = {req_imm[DATA_LEN-1:12], req_rd, OPC_LUI};
            OP_AUIPC: enc_word = {req_imm[DATA_LEN-1:12], req_rd, OPC_AUIPC};
            OP_JAL: begin
                enc_err  = req_imm[0] | ~fits21;
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
            end
`ifdef YSYX_22041211_ENC_LI_EN
            OP_LI: begin
                if (fits12) begin
                    enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM};
                end else begin
                    enc_word = {li_hi, req_rd, OPC_LUI};
                    enc_two  = |req_imm[11:0];
                end
            end
`endif
            default: enc_err = 1'b1;
        endcase
    end

    // Back-pressure looks at the registered count only; a pop in the same cycle frees no slot.
    assign space  = (count < DEPTH_C);
    assign accept = req_valid && req_ready;
    assign pop    = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef YSYX_22041211_ENC_LI_EN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !enc_err && enc_two) state_nxt = LI_LO;
            LI_LO:   if (space) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lo_rd  <= req_rd;
            lo_imm <= req_imm[11:0];
        end
    end
`else
    always_comb state_nxt = IDLE;
`endif

    always_comb begin
        req_ready = 1'b0;
        push      = 1'b0;
        push_word = enc_word;
        case (state)
            IDLE: begin
                req_ready = !rst && space;
                push      = req_valid && req_ready && !enc_err;
            end
`ifdef YSYX_22041211_ENC_LI_EN
            LI_LO: begin
                push      = space;
                push_word = lo_word;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            imm_err <= 1'b0;
        end else begin
            imm_err <= accept && enc_err;
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_word;
    end

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? mem[rptr] : '0;
    assign dbg_state  = state;
    assign dbg_count  = count;

endmodule

// File: tb/tb_ysyx_22041211_instenc.sv
// Bench for ysyx_22041211_instenc: directed vector table, randomized requests against a reference encoder,
// plus full/wrap, LI back-pressure and reset-in-LI_LO sequences.
`timescale 1ns/1ps
module tb_ysyx_22041211_instenc;

    localparam int DATA_LEN = 32;
    localparam int DEPTH    = 4;

`ifdef YSYX_22041211_ENC_LI_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [2:0]            req_op    = '0;
    logic [4:0]            req_rd    = '0;
    logic [4:0]            req_rs1   = '0;
    logic [DATA_LEN-1:0]   req_imm   = '0;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_LEN-1:0]   inst;
    logic                  imm_err;
    logic                  dbg_state;
    logic [$clog2(DEPTH):0] dbg_count;

    logic ready_man = 1'b0;
    logic rand_rdy  = 1'b0;
    logic rnd_bit;
    assign inst_ready = rand_rdy ? rnd_bit : ready_man;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    ysyx_22041211_instenc #(.DATA_LEN(DATA_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_imm(req_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .imm_err(imm_err), .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %h expected no word", inst);
                end else begin
                    check("pop_word", inst, exp_q.pop_front());
                end
            end else if (!inst_valid) begin
                check("empty_inst_zero", inst, 32'h0);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] addi_w(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] lui_w(input logic [4:0] rd, input logic [31:0] upper);
        return (upper & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
    endfunction

    function automatic void model(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [31:0] imm, output bit err, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
        longint s;
        logic [31:0] lo_s;
        s   = longint'($signed(imm));
        err = 1'b0;
        n   = 1;
        w0  = '0;
        w1  = '0;
        case (op)
            3'd0: begin
                err = (s < -2048) || (s > 2047);
                w0  = addi_w(rd, rs1, imm);
            end
            3'd1: w0 = lui_w(rd, imm);
            3'd2: w0 = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h17;
            3'd3: begin
                err = (imm % 2 != 0) || (s < -1048576) || (s > 1048574);
                w0  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                      (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000) | (32'(rd) << 7) | 32'h6F;
            end
            3'd4: begin
                if (!LI_EN) begin
                    err = 1'b1;
                end else if (s >= -2048 && s <= 2047) begin
                    w0 = addi_w(rd, 5'd0, imm);
                end else begin
                    // value = upper + sext(low): take the signed low part out first
                    lo_s = {{20{imm[11]}}, imm[11:0]};
                    w0   = lui_w(rd, imm - lo_s);
                    if ((imm & 32'hFFF) != 0) begin
                        n  = 2;
                        w1 = addi_w(rd, rd, lo_s);
                    end
                end
            end
            default: err = 1'b1;
        endcase
        if (err) n = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [31:0] imm, input bit exp_err, input int n,
                        input logic [31:0] w0, input logic [31:0] w1);
        int waited;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_imm   = imm;
        if (n > 0) exp_q.push_back(w0);
        if (n > 1) exp_q.push_back(w1);
        waited = 0;
        @(negedge clk);
        check("imm_err_clear", imm_err, 1'b0);
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 after %0d cycles expected 1", waited);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("imm_err", imm_err, exp_err);
    endtask

    task automatic send_model(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] imm);
        bit e;
        int n;
        logic [31:0] w0, w1;
        model(op, rd, rs1, imm, e, n, w0, w1);
        send(op, rd, rs1, imm, e, n, w0, w1);
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        @(posedge clk); #1;
        ready_man = 1'b1;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        ready_man = 1'b0;
        @(negedge clk);
        check({name, "_left"}, exp_q.size(), 32'd0);
        check({name, "_empty"}, inst_valid, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        bit          err;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm,
                       input bit err, input int n, input logic [31:0] w0, input logic [31:0] w1);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.imm = imm;
        v.err = err; v.n = n; v.w0 = w0; v.w1 = w1;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [11];
        edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'h000FFFFE, 32'h000FFFFF,
                  32'hFFF00000, 32'hFFEFFFFE, 32'h0, 32'h800, 32'h12345000};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       return edges[$urandom_range(0, 10)];
            default: return ($urandom & 32'h001FFFFE) | ((($urandom % 2) != 0) ? 32'hFFE00000 : 32'h0);
        endcase
    endfunction

    // ---------------- main test ----------------
    initial begin
        add(3'd0, 5'd1,  5'd0, 32'hFFFFFFFF, 1'b0, 1, 32'hFFF00093, 32'h0);
        add(3'd1, 5'd5,  5'd0, 32'h12345ABC, 1'b0, 1, 32'h123452B7, 32'h0);
        add(3'd3, 5'd1,  5'd0, 32'h00000800, 1'b0, 1, 32'h001000EF, 32'h0);
        add(3'd2, 5'd3,  5'd0, 32'hFFFFF123, 1'b0, 1, 32'hFFFFF197, 32'h0);
        add(3'd0, 5'd2,  5'd3, 32'd2047,     1'b0, 1, 32'h7FF18113, 32'h0);
        add(3'd0, 5'd0,  5'd0, 32'hFFFFF800, 1'b0, 1, 32'h80000013, 32'h0);
        add(3'd0, 5'd1,  5'd0, 32'd2048,     1'b1, 0, 32'h0, 32'h0);
        add(3'd0, 5'd1,  5'd0, 32'hFFFFF7FF, 1'b1, 0, 32'h0, 32'h0);
        add(3'd3, 5'd1,  5'd0, 32'd3,        1'b1, 0, 32'h0, 32'h0);
        add(3'd3, 5'd0,  5'd0, 32'h000FFFFE, 1'b0, 1, 32'h7FFFF06F, 32'h0);
        add(3'd3, 5'd0,  5'd0, 32'hFFF00000, 1'b0, 1, 32'h8000006F, 32'h0);
        add(3'd3, 5'd0,  5'd0, 32'h00100000, 1'b1, 0, 32'h0, 32'h0);
        add(3'd7, 5'd1,  5'd0, 32'd5,        1'b1, 0, 32'h0, 32'h0);
        add(3'd5, 5'd1,  5'd0, 32'd5,        1'b1, 0, 32'h0, 32'h0);
`ifdef YSYX_22041211_ENC_LI_EN
        add(3'd4, 5'd10, 5'd0, 32'h12345FFF, 1'b0, 2, 32'h12346537, 32'hFFF50513);
        add(3'd4, 5'd10, 5'd0, 32'd5,        1'b0, 1, 32'h00500513, 32'h0);
        add(3'd4, 5'd10, 5'd0, 32'h12345000, 1'b0, 1, 32'h12345537, 32'h0);
        add(3'd4, 5'd10, 5'd0, 32'hFFFFF800, 1'b0, 1, 32'h80000513, 32'h0);
        add(3'd4, 5'd10, 5'd0, 32'h00000800, 1'b0, 2, 32'h00001537, 32'h80050513);
`else
        add(3'd4, 5'd10, 5'd0, 32'd5,        1'b1, 0, 32'h0, 32'h0);
`endif

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_imm_err", imm_err, 1'b0);
        check("rst_count", dbg_count, 32'd0);
        check("rst_state", dbg_state, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);

        // directed table: head word visible one cycle after accept
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].imm, tbl[i].err, tbl[i].n, tbl[i].w0, tbl[i].w1);
            check($sformatf("vec%0d_valid", i), inst_valid, (tbl[i].n > 0) ? 1'b1 : 1'b0);
            check($sformatf("vec%0d_head", i), inst, (tbl[i].n > 0) ? tbl[i].w0 : 32'h0);
            drain($sformatf("vec%0d_drain", i));
        end

        // full FIFO, then a single pop frees one slot
        for (int i = 0; i < DEPTH; i++)
            send_model(3'd0, 5'(i + 1), 5'(i), 32'(i * 100));
        check("full_ready", req_ready, 1'b0);
        check("full_count", dbg_count, 32'(DEPTH));
        @(posedge clk); #1;
        ready_man = 1'b1;
        @(negedge clk);
        check("full_pop_no_bypass", req_ready, 1'b0);
        @(posedge clk); #1;
        ready_man = 1'b0;
        @(negedge clk);
        check("after_pop_ready", req_ready, 1'b1);
        check("after_pop_count", dbg_count, 32'(DEPTH - 1));
        @(posedge clk); #1;
        ready_man = 1'b1;
        for (int i = 0; i < 10; i++)
            send_model(3'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       32'($urandom_range(0, 4095)) - 32'd2048);
        drain("wrap_drain");

`ifdef YSYX_22041211_ENC_LI_EN
        // LI expansion holds req_ready low for one cycle
        send_model(3'd4, 5'd10, 5'd0, 32'h12345FFF);
        check("li_lo_ready", req_ready, 1'b0);
        check("li_lo_state", dbg_state, 1'b1);
        check("li_lo_head", inst, 32'h12346537);
        @(negedge clk);
        check("li_back_ready", req_ready, 1'b1);
        check("li_back_count", dbg_count, 32'd2);
        drain("li_drain");

        // reset while in LI_LO with three words queued
        send_model(3'd0, 5'd1, 5'd2, 32'd7);
        send_model(3'd0, 5'd3, 5'd4, 32'd9);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_rd    = 5'd7;
        req_imm   = 32'h12345678;
        @(negedge clk);
        check("rst_mid_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("rst_mid_state", dbg_state, 1'b1);
        check("rst_mid_count", dbg_count, 32'd3);
        check("rst_mid_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_valid", inst_valid, 1'b0);
        check("rst_mid_inst", inst, 32'h0);
        check("rst_mid_count0", dbg_count, 32'd0);
        check("rst_mid_idle", dbg_state, 1'b0);
        @(posedge clk); #1;
        ready_man = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_late_addi", inst_valid, 1'b0);
        end
        @(posedge clk); #1;
        ready_man = 1'b0;
`endif

        // randomized requests with random consumer stalls
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++)
            send_model(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       rand_imm());
        @(posedge clk); #1;
        rand_rdy = 1'b0;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected test end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
